inexrecur_regfile: RTL
======================

INEXRECUR_REGFILE -- requirements
Module: inexrecur_regfile

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of entries, power of two, at most 4096.
REQ-002 SHALL have parameter AW, default 12, address width (log2 DEPTH).
REQ-003 SHALL have port clk, in, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, in, 1; reset is synchronous and active-high.
REQ-005 SHALL have port clear, in, 1, synchronous logical flush: count and pointers to 0; array contents untouched.
REQ-006 SHALL have ports re_seq / re_ran, in, 1 each, sequential-read and random-read enables.
REQ-007 SHALL have port r_addr, in, AW, random-read address.
REQ-008 SHALL have ports seq_we_InexRecur / seq_we_state, in, 1 each, append-at-tail field write enables.
REQ-009 SHALL have ports seq_w_data_InexRecur, in, 32, and seq_w_data_state, in, 18, append data.
REQ-010 SHALL have ports ran_we_InexRecur / ran_we_state, in, 1 each, random field write enables.
REQ-011 SHALL have ports ran_w_addr_InexRecur / ran_w_addr_state, in, AW each, and ran_w_data_InexRecur, in, 32, and ran_w_data_state, in, 18.
REQ-012 SHALL have outputs rd_addr_o (AW), InexRecur_data_o (32), state_data_o (18), rd_valid_o (1): read response.
REQ-013 SHALL have outputs count_o (AW+1), empty_o, full_o, overflow_o (sticky), addr_err_o (sticky).

Function
REQ-014 Each entry SHALL hold a 32-bit InexRecur field and an 18-bit state field at the same index.
REQ-015 Read latency SHALL be exactly 1 cycle: rd_valid_o, rd_addr_o and both data fields are registered together.
REQ-016 re_seq with count>0 SHALL read index seq_ptr, then seq_ptr increments; if seq_ptr+1 = count it wraps to 0.
REQ-017 re_seq with count=0 SHALL produce no response (rd_valid_o low, seq_ptr unchanged).
REQ-018 re_ran SHALL read r_addr regardless of count; re_ran and re_seq together: random read served, seq_ptr not advanced.
REQ-019 Either seq_we_* high SHALL write enabled fields at index count and increment count by 1; a disabled field at that index is left unchanged.
REQ-020 Append when full (count=DEPTH) SHALL be dropped and set overflow_o.
REQ-021 Random write to address >= count SHALL be dropped and set addr_err_o; the valid field write of the same cycle still proceeds.
REQ-022 Append and random writes in one cycle SHALL both commit (addresses cannot collide since random address < count).
REQ-023 Random writes to InexRecur and state fields SHALL use their own addresses independently.
REQ-024 Read and write to the same index in one cycle SHALL return old data (read-first) unless REGFILE_BYPASS_EN is defined.
REQ-025 clear SHALL take priority over all writes/reads that cycle; rd_valid_o low next cycle; flags cleared.
REQ-026 empty_o SHALL equal (count=0); full_o SHALL equal (count=DEPTH); both combinational from count.

Reset
REQ-027 rst SHALL set count, seq_ptr, rd_valid_o, rd_addr_o, data outputs, overflow_o, addr_err_o to 0; array contents undefined.
REQ-028 rst SHALL override clear and all enables; writes and reads in a reset cycle are discarded, including mid-operation.

Configuration
REQ-029 With REGFILE_BYPASS_EN defined, a read whose index equals a same-cycle write index SHALL return the newly written field(s), per field.
REQ-030 Without REGFILE_BYPASS_EN, same-cycle read/write SHALL return pre-write contents; no forwarding logic is present.

Verification
REQ-031 Reset, append 3 entries (0x11/0x01, 0x22/0x02, 0x33/0x03), re_seq x4 -> rd_addr_o 0,1,2,0 with matching data, one cycle after each enable.
REQ-032 Append DEPTH entries, then one more -> count_o=DEPTH, full_o=1, overflow_o=1, entry 0 unchanged.
REQ-033 count=2, ran_we_InexRecur addr 5 data 0xDEAD plus ran_we_state addr 1 data 0x3FFFF -> addr_err_o=1, state[1]=0x3FFFF, InexRecur unchanged.
REQ-034 re_seq and re_ran r_addr=1 together at seq_ptr=0 -> response rd_addr_o=1, next re_seq returns index 0.
REQ-035 Same-cycle ran_we addr 0 data 0xAAAA and re_ran addr 0 -> 0xAAAA with REGFILE_BYPASS_EN, old value without.
REQ-036 clear during append, then rst during append -> count_o=0 and no entry written in either cycle.

Source files
------------

// File: rtl/inexrecur_regfile.sv
// Dual-field (32-bit InexRecur + 18-bit state) register file with append, random write, sequential and random read.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a read of the same index, per field.
module inexrecur_regfile #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              re_seq,
  input  logic              re_ran,
  input  logic [AW-1:0]     r_addr,
  input  logic              seq_we_InexRecur,
  input  logic              seq_we_state,
  input  logic [31:0]       seq_w_data_InexRecur,
  input  logic [17:0]       seq_w_data_state,
  input  logic              ran_we_InexRecur,
  input  logic              ran_we_state,
  input  logic [AW-1:0]     ran_w_addr_InexRecur,
  input  logic [AW-1:0]     ran_w_addr_state,
  input  logic [31:0]       ran_w_data_InexRecur,
  input  logic [17:0]       ran_w_data_state,
  output logic [AW-1:0]     rd_addr_o,
  output logic [31:0]       InexRecur_data_o,
  output logic [17:0]       state_data_o,
  output logic              rd_valid_o,
  output logic [AW:0]       count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              addr_err_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   inex_mem  [DEPTH];
  logic [17:0]   state_mem [DEPTH];

  logic [AW:0]   count_q;
  logic [AW-1:0] seq_ptr_q;
  logic [AW-1:0] seq_ptr_next;

  logic          active;
  logic          append_req;
  logic          append_ok;
  logic          append_drop;
  logic [AW-1:0] tail_idx;
  logic          app_inex_we;
  logic          app_state_we;
  logic          ran_inex_ok;
  logic          ran_state_ok;
  logic          ran_inex_err;
  logic          ran_state_err;

  logic          rd_ran;
  logic          rd_seq;
  logic          rd_fire;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_inex_data;
  logic [17:0]   rd_state_data;

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);

  // Reset and clear both suppress every write and read of their cycle.
  assign active     = !rst && !clear;
  assign append_req = seq_we_InexRecur || seq_we_state;
  assign append_ok  = active && append_req && !full_o;
  assign append_drop = active && append_req && full_o;
  assign tail_idx   = count_q[AW-1:0];

  assign app_inex_we  = append_ok && seq_we_InexRecur;
  assign app_state_we = append_ok && seq_we_state;

  // Random writes may only touch already-populated entries.
  assign ran_inex_ok   = active && ran_we_InexRecur && ({1'b0, ran_w_addr_InexRecur} < count_q);
  assign ran_state_ok  = active && ran_we_state && ({1'b0, ran_w_addr_state} < count_q);
  assign ran_inex_err  = active && ran_we_InexRecur && !({1'b0, ran_w_addr_InexRecur} < count_q);
  assign ran_state_err = active && ran_we_state && !({1'b0, ran_w_addr_state} < count_q);

  // Random read wins over sequential; the sequential pointer only moves when it is served.
  assign rd_ran  = active && re_ran;
  assign rd_seq  = active && re_seq && !re_ran && !empty_o;
  assign rd_fire = rd_ran || rd_seq;
  assign rd_idx  = re_ran ? r_addr : seq_ptr_q;

  assign seq_ptr_next = (({1'b0, seq_ptr_q} + (AW+1)'(1)) == count_q) ? '0 : seq_ptr_q + AW'(1);

`ifdef REGFILE_BYPASS_EN
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rd_inex_data  = inex_mem[rd_idx];
    rd_state_data = state_mem[rd_idx];
    if (ran_inex_ok && (ran_w_addr_InexRecur == rd_idx)) rd_inex_data = ran_w_data_InexRecur;
    if (app_inex_we && (tail_idx == rd_idx))             rd_inex_data = seq_w_data_InexRecur;
    if (ran_state_ok && (ran_w_addr_state == rd_idx))    rd_state_data = ran_w_data_state;
    if (app_state_we && (tail_idx == rd_idx))            rd_state_data = seq_w_data_state;
  end
`else
  assign rd_inex_data  = inex_mem[rd_idx];
  assign rd_state_data = state_mem[rd_idx];
`endif

  // NOTE: the storage arrays have no reset so they can map onto RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (app_inex_we)  inex_mem[tail_idx]             <= seq_w_data_InexRecur;
    if (ran_inex_ok)  inex_mem[ran_w_addr_InexRecur] <= ran_w_data_InexRecur;
    if (app_state_we) state_mem[tail_idx]            <= seq_w_data_state;
    if (ran_state_ok) state_mem[ran_w_addr_state]    <= ran_w_data_state;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q          <= '0;
      seq_ptr_q        <= '0;
      rd_valid_o       <= 1'b0;
      rd_addr_o        <= '0;
      InexRecur_data_o <= '0;
      state_data_o     <= '0;
      overflow_o       <= 1'b0;
      addr_err_o       <= 1'b0;
    end else if (clear) begin
      count_q    <= '0;
      seq_ptr_q  <= '0;
      rd_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      addr_err_o <= 1'b0;
    end else begin
      if (append_ok) count_q <= count_q + (AW+1)'(1);
      if (rd_seq)    seq_ptr_q <= seq_ptr_next;
      rd_valid_o <= rd_fire;
      if (rd_fire) begin
        rd_addr_o        <= rd_idx;
        InexRecur_data_o <= rd_inex_data;
        state_data_o     <= rd_state_data;
      end
      if (append_drop)                  overflow_o <= 1'b1;
      if (ran_inex_err || ran_state_err) addr_err_o <= 1'b1;
    end
  end

endmodule
